// File: rtl/acoustics_pkg.sv
// Shared constants and types for the hydrophone acoustics chain.
// FRAME_LEN must be a power of two so frame indices wrap naturally.
package acoustics_pkg;

  localparam int unsigned FRAME_LEN       = 64;
  localparam int unsigned SAMPLE_WIDTH    = 16;
  localparam int unsigned AXIS_DATA_WIDTH = 32;
  localparam int unsigned FRAME_IDX_WIDTH = $clog2(FRAME_LEN);

  typedef logic [FRAME_IDX_WIDTH-1:0] frame_idx_t;

  localparam frame_idx_t LAST_IDX = frame_idx_t'(FRAME_LEN - 1);

endpackage

// File: rtl/fft_frame_source_if.sv
// AXI-Stream link from fft_frame_source (master) to the FFT core (slave).
//   T_DATA  : {imag = 0, real sample}
//   T_VALID : beat valid
//   T_READY : slave ready
//   T_LAST  : final beat of a frame
interface fft_frame_source_if;
  import acoustics_pkg::*;

  logic [AXIS_DATA_WIDTH-1:0] T_DATA;
  logic                       T_VALID;
  logic                       T_READY;
  logic                       T_LAST;

  modport master (
    output T_DATA,
    output T_VALID,
    output T_LAST,
    input  T_READY
  );

  modport slave (
    input  T_DATA,
    input  T_VALID,
    input  T_LAST,
    output T_READY
  );

endinterface

// File: rtl/pingpong_frame_buf.sv
// Two-bank register file holding one frame per bank.
//   clk_i                           : write clock
//   wr_en_i/wr_bank_i/wr_idx_i/wr_data_i : synchronous write port
//   rd_bank_i/rd_idx_i -> rd_data_o : asynchronous read port
// Contents are not reset; the control logic never reads a bank before filling it.
module pingpong_frame_buf
  import acoustics_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    wr_en_i,
  input  logic                    wr_bank_i,
  input  frame_idx_t              wr_idx_i,
  input  logic [SAMPLE_WIDTH-1:0] wr_data_i,
  input  logic                    rd_bank_i,
  input  frame_idx_t              rd_idx_i,
  output logic [SAMPLE_WIDTH-1:0] rd_data_o
);

  logic [SAMPLE_WIDTH-1:0] mem_q [2][FRAME_LEN];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_idx_i];

endmodule

// File: rtl/fft_frame_source.sv
// Collects strobed ADC samples into a ping-pong buffer and streams each full
// bank to the FFT as one AXI-Stream frame.
//   clk, reset_b          : clock, async active-low reset
//   Sample_Data/Valid     : one-cycle sample strobe
//   Enable                : accept samples; low discards any partial frame
//   Overflow_Clear        : clears the sticky Overflow flag
//   axis                  : AXI-Stream master towards the FFT
//   Overflow              : sticky, a sample was dropped because no bank was free
//   Frame_Count           : frames completed on the stream (wraps)
module fft_frame_source
  import acoustics_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [SAMPLE_WIDTH-1:0] Sample_Data,
  input  logic                    Sample_Valid,
  input  logic                    Enable,
  input  logic                    Overflow_Clear,
  fft_frame_source_if.master      axis,
  output logic                    Overflow,
  output logic [15:0]             Frame_Count
);

  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  frame_idx_t wr_idx_q, wr_idx_d;
  frame_idx_t rd_idx_q, rd_idx_d;
  logic [1:0] full_q, full_d;
  logic       overflow_q, overflow_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic t_valid, handshake, last_hs;
  logic wr_en, wr_done, drop;
  logic [SAMPLE_WIDTH-1:0] rd_data;

  always_comb begin
    t_valid   = full_q[rb_q];
    handshake = t_valid && axis.T_READY;
    last_hs   = handshake && (rd_idx_q == LAST_IDX);
    wr_en     = Sample_Valid && Enable && !full_q[wb_q];
    drop      = Sample_Valid && Enable && full_q[wb_q];
    wr_done   = wr_en && (wr_idx_q == LAST_IDX);
  end

  always_comb begin
    full_d = full_q;
    if (last_hs) full_d[rb_q] = 1'b0;
    if (wr_done) full_d[wb_q] = 1'b1;

    // Move to the other bank once ours is full and the other is free; this
    // covers both the same-edge toggle and the deferred toggle on release.
    wb_d = wb_q;
    if (full_d[wb_q] && !full_d[~wb_q]) wb_d = ~wb_q;

    wr_idx_d = wr_idx_q;
    if (!Enable) begin
      wr_idx_d = '0;
    end else if (wr_en) begin
      wr_idx_d = wr_done ? '0 : frame_idx_t'(wr_idx_q + 1'b1);
    end

    rd_idx_d      = rd_idx_q;
    rb_d          = rb_q;
    frame_count_d = frame_count_q;
    if (handshake) begin
      rd_idx_d = last_hs ? '0 : frame_idx_t'(rd_idx_q + 1'b1);
    end
    if (last_hs) begin
      rb_d          = ~rb_q;
      frame_count_d = frame_count_q + 16'd1;
    end

    // A drop in the same cycle as a clear wins.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (Overflow_Clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      full_q        <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  pingpong_frame_buf u_buf (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wb_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (Sample_Data),
    .rd_bank_i (rb_q),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (rd_data)
  );

  // Data is gated so the bus reads zero whenever no beat is offered.
  assign axis.T_VALID = t_valid;
  assign axis.T_LAST  = t_valid && (rd_idx_q == LAST_IDX);
  assign axis.T_DATA  = t_valid ? {{(AXIS_DATA_WIDTH - SAMPLE_WIDTH){1'b0}}, rd_data} : '0;

  assign Overflow    = overflow_q;
  assign Frame_Count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_source.sv
// Scoreboard bench for fft_frame_source: stimulus pushes expected beats,
// a negedge monitor pops and compares on each handshake and checks that
// stalled beats are held stable.
module tb_fft_frame_source;
  import acoustics_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] Sample_Data = '0;
  logic        Sample_Valid = 1'b0;
  logic        Enable = 1'b0;
  logic        Overflow_Clear = 1'b0;
  logic        Overflow;
  logic [15:0] Frame_Count;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t exp_q[$];
  beat_t mon_exp;
  logic        stall = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  always #5 clk = ~clk;

  fft_frame_source_if axis ();

  fft_frame_source dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .Sample_Data    (Sample_Data),
    .Sample_Valid   (Sample_Valid),
    .Enable         (Enable),
    .Overflow_Clear (Overflow_Clear),
    .axis           (axis),
    .Overflow       (Overflow),
    .Frame_Count    (Frame_Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int idx, input logic [15:0] v);
    exp_q.push_back('{data: {16'h0000, v}, last: (idx == FRAME_LEN - 1)});
  endtask

  // Called in the phase just after a rising edge; returns in the same phase.
  task automatic send_sample(input logic [15:0] v);
    Sample_Data  = v;
    Sample_Valid = 1'b1;
    @(posedge clk);
    #1;
    Sample_Valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || axis.T_VALID) && cyc < 3000) begin
      if (toggle) axis.T_READY = ~axis.T_READY;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({"drain_", name}, 32'(cyc < 3000), 32'd1);
  endtask

  // Monitor: compare on handshake, verify hold while stalled.
  always @(negedge clk) begin
    if (!reset_b) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(axis.T_VALID), 32'd1);
        check("hold_data", axis.T_DATA, stall_data);
        check("hold_last", 32'(axis.T_LAST), 32'(stall_last));
      end
      if (axis.T_VALID && axis.T_READY) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h, required no beat", axis.T_DATA);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat_data", axis.T_DATA, mon_exp.data);
          check("beat_last", 32'(axis.T_LAST), 32'(mon_exp.last));
        end
      end
      stall      = axis.T_VALID && !axis.T_READY;
      stall_data = axis.T_DATA;
      stall_last = axis.T_LAST;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    axis.T_READY = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(axis.T_VALID), 32'd0);
    check("rst_last", 32'(axis.T_LAST), 32'd0);
    check("rst_data", axis.T_DATA, 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_frame_count", 32'(Frame_Count), 32'd0);
    reset_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_valid", 32'(axis.T_VALID), 32'd0);

    // Single frame, values 0..63, latency of first beat
    Enable       = 1'b1;
    axis.T_READY = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      expect_beat(i, 16'(i));
      if (i == FRAME_LEN - 1) check("valid_before_last", 32'(axis.T_VALID), 32'd0);
      send_sample(16'(i));
    end
    check("valid_after_last", 32'(axis.T_VALID), 32'd1);
    drain(1'b0, "single");
    check("fc_single", 32'(Frame_Count), 32'd1);

    // Backpressure with T_READY toggling; sample 5 is -5
    axis.T_READY = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic [15:0] v;
      v = (i == 5) ? 16'hFFFB : 16'(200 + i);
      expect_beat(i, v);
      send_sample(v);
    end
    drain(1'b1, "backpressure");
    axis.T_READY = 1'b1;
    check("fc_bp", 32'(Frame_Count), 32'd2);

    // Overflow: both banks fill, 128 and 129 dropped
    axis.T_READY = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (i < 128) expect_beat(i % FRAME_LEN, 16'(i));
      send_sample(16'(i));
    end
    check("ovf_set", 32'(Overflow), 32'd1);
    Overflow_Clear = 1'b1;
    send_sample(16'hDEAD);
    Overflow_Clear = 1'b0;
    check("ovf_set_beats_clear", 32'(Overflow), 32'd1);
    axis.T_READY = 1'b1;
    drain(1'b0, "overflow");
    check("fc_ovf", 32'(Frame_Count), 32'd4);
    Overflow_Clear = 1'b1;
    @(posedge clk);
    #1;
    Overflow_Clear = 1'b0;
    check("ovf_clear", 32'(Overflow), 32'd0);

    // Last handshake of bank 0 on the same edge as the 64th write into bank 1
    axis.T_READY = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      expect_beat(i, 16'(1000 + i));
      send_sample(16'(1000 + i));
    end
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      expect_beat(i, 16'(2000 + i));
      send_sample(16'(2000 + i));
    end
    expect_beat(FRAME_LEN - 1, 16'(2000 + FRAME_LEN - 1));
    axis.T_READY = 1'b1;
    repeat (FRAME_LEN - 1) begin
      @(posedge clk);
      #1;
    end
    send_sample(16'(2000 + FRAME_LEN - 1));
    check("fc_simul_edge", 32'(Frame_Count), 32'd5);
    for (int i = 0; i < FRAME_LEN; i++) begin
      expect_beat(i, 16'(3000 + i));
      send_sample(16'(3000 + i));
    end
    check("simul_no_drop", 32'(Overflow), 32'd0);
    drain(1'b0, "simul");
    check("fc_simul", 32'(Frame_Count), 32'd7);

    // Reset during beat 20
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < 20) expect_beat(i, 16'(4000 + i));
      send_sample(16'(4000 + i));
    end
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    reset_b = 1'b0;
    #1;
    check("midrst_valid", 32'(axis.T_VALID), 32'd0);
    check("midrst_fc", 32'(Frame_Count), 32'd0);
    check("midrst_beats_seen", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("postrst_idle", 32'(axis.T_VALID), 32'd0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      expect_beat(i, 16'(4500 + i));
      send_sample(16'(4500 + i));
    end
    drain(1'b0, "postrst");
    check("fc_postrst", 32'(Frame_Count), 32'd1);

    // Enable low after 10 samples discards the partial frame
    for (int i = 0; i < 10; i++) send_sample(16'(5000 + i));
    Enable = 1'b0;
    send_sample(16'h7777);
    check("disabled_no_ovf", 32'(Overflow), 32'd0);
    Enable = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      expect_beat(i, 16'(6000 + i));
      send_sample(16'(6000 + i));
    end
    drain(1'b0, "enable");
    check("fc_enable", 32'(Frame_Count), 32'd2);
    check("enable_no_ovf", 32'(Overflow), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_source.md
# fft_frame_source

AXI-Stream master that turns the free-running hydrophone sample strobe into back-to-back 64-point frames for the FFT core's slave input. It sits between the ADC capture logic and the FFT: it writes samples into a two-bank ping-pong buffer and streams each completed bank as one frame with `T_LAST`. The downstream trigger detector consumes the FFT output frames this block produces.

## Interface
- `FRAME_LEN`, 64, samples per frame; must be a power of two.
- `SAMPLE_WIDTH`, 16, signed real sample width.
- `clk` input 1 — single clock; all logic on its rising edge.
- `reset_b` input 1 — asynchronous, active-low reset.
- `Sample_Data` input 16 — signed 2's-complement ADC sample.
- `Sample_Valid` input 1 — one-cycle strobe; `Sample_Data` is valid in that cycle.
- `Enable` input 1 — high: accept samples; low: ignore samples.
- `Overflow_Clear` input 1 — one-cycle pulse that clears `Overflow`.
- `T_DATA` output 32 — `{16'h0000 imag, sample real}`.
- `T_VALID` output 1 — frame beat valid.
- `T_READY` input 1 — FFT slave ready.
- `T_LAST` output 1 — high on beat `FRAME_LEN-1`.
- `Overflow` output 1 — sticky; a sample was dropped.
- `Frame_Count` output 16 — completed frames sent (last handshake), wraps at 2^16.

## Operation
- Storage: 2 banks × `FRAME_LEN` × 16 bits, register-based with asynchronous read. State: `wb` (write bank), `rb` (read bank), `wr_idx`, `rd_idx` (6 bits each), and `full[1:0]`.
- Write side: if `Sample_Valid && Enable && !full[wb]`, store the sample at `mem[wb][wr_idx]` and increment `wr_idx`.
- On the write at `wr_idx == FRAME_LEN-1`:
  - set `full[wb]` and wrap `wr_idx` to 0;
  - toggle `wb` at the same edge if `full[~wb]` is 0, or if it is being released in that same cycle;
  - otherwise hold `wb`, and toggle it at the edge on which `~wb` is released.
- Drop: if `Sample_Valid && Enable && full[wb]`, the sample is discarded and `Overflow` is set. Storage and indices are unchanged.
- `Enable` low:
  - samples are ignored, with no overflow;
  - `wr_idx` is forced to 0, so a partial frame is discarded;
  - full banks still stream.
- Read side:
  - `T_VALID = full[rb]`, `T_DATA = {16'h0, mem[rb][rd_idx]}`, `T_LAST = T_VALID && rd_idx == FRAME_LEN-1`.
  - On each handshake (`T_VALID && T_READY`), increment `rd_idx`.
  - On the last handshake: clear `full[rb]`, toggle `rb`, wrap `rd_idx` to 0, and increment `Frame_Count`.
- Frame order: banks strictly alternate, so frames leave in capture order.
- `Overflow`: set has priority over `Overflow_Clear` when both occur in the same cycle.

## Timing
- Reset values: `T_VALID` 0, `T_LAST` 0, `T_DATA` 0, `Overflow` 0, `Frame_Count` 0, `wb`/`rb`/indices/`full` 0. Memory contents are don't-care.
- Reset takes effect asynchronously: `T_VALID` drops immediately, even mid-frame, and no partial frame resumes after release.
- Latency: 64th sample written at edge E → `T_VALID` high in the cycle after E, beat 0 presented.
- Throughput: one beat per cycle with `T_READY` held high. A frame takes 64 cycles, which is far faster than the sample rate.
- AXI rule: once `T_VALID` is high it stays high, and `T_DATA`/`T_LAST` are held, until the handshake. `T_VALID` never depends combinationally on `T_READY`.
- Back-to-back frames: if the other bank is full at the last handshake, `T_VALID` stays high and the next cycle presents beat 0 of the next frame.
- Write and read never target the same bank, because `full[wb]` blocks writes.

## Structure
- Shared package `acoustics_pkg`: `FRAME_LEN`, `SAMPLE_WIDTH`, `AXIS_DATA_WIDTH = 32`, and a frame index type of `$clog2(FRAME_LEN)` bits.
- One sub-module, `pingpong_frame_buf`: the 2-bank register file with write port (bank, index, data, enable) and asynchronous read port (bank, index).
- Bank/index control and the AXI side live in the top module.

## Test plan
- Reset: hold `reset_b` low → all outputs 0. Release with no samples → `T_VALID` stays 0.
- Single frame: 64 strobes with data `i` = 0..63, `T_READY` = 1.
  - Required: 64 beats with `T_DATA = {16'h0, i}`; `T_LAST` only on `i` = 63; `Frame_Count` = 1.
  - Also check that a sample of -5 appears as `32'h0000FFFB`.
- Backpressure: `T_READY` toggled 1/0 per cycle → each beat held stable while `T_READY` = 0; all 64 values delivered in order, with none lost or duplicated.
- Overflow: `T_READY` = 0, 130 strobes of values 0..129.
  - Required: samples 128 and 129 dropped and `Overflow` = 1.
  - Then set `T_READY` = 1: frames 0..63 and 64..127 emitted, `Frame_Count` = 2.
  - `Overflow_Clear` pulse → `Overflow` = 0.
- Simultaneous events: the last handshake of bank 0 occurs in the same cycle as the 64th write into bank 1, and a strobe arrives the next cycle → no drop, and that sample becomes beat 0 of the third frame.
- Mid-operation events:
  - `reset_b` low during beat 20 → `T_VALID` 0 at once; after release, fresh samples form a new frame starting at index 0.
  - `Enable` low after 10 samples → those 10 are discarded and the next frame starts at the first sample after `Enable` returns high.
